// File: rtl/int_rs_types.sv
// Shared integer-pipeline types for the FU -> CDB writeback path.
// Holds the FU result register layout, the per-consumer CDB views and the
// registered lane format used inside the CDB arbiter.
package int_rs_types;

   localparam int XLEN      = 32;
   localparam int ROB_DEPTH = 32;
   localparam int ROB_IDX   = $clog2(ROB_DEPTH);
   localparam int ARCH_REGS = 32;
   localparam int ARCH_IDX  = $clog2(ARCH_REGS);
   localparam int PRF_DEPTH = 64;
   localparam int PRF_IDX   = $clog2(PRF_DEPTH);

   // Broadcast lanes per cycle and number of FU writeback sources.
   localparam int CDB_WIDTH = 2;
   localparam int CDB_SRC   = 4;

   // Result register presented by each functional unit.
   typedef struct packed {
      logic [ROB_IDX-1:0]  rob_id;
      logic [ARCH_IDX-1:0] rd_arch;
      logic [PRF_IDX-1:0]  rd_phy;
      logic [XLEN-1:0]     rd_value;
      logic [XLEN-1:0]     rs1_dbg;
      logic [XLEN-1:0]     rs2_dbg;
   } fu_cdb_reg_t;

   // Physical register file write port.
   typedef struct packed {
      logic                valid;
      logic [PRF_IDX-1:0]  rd_phy;
      logic [XLEN-1:0]     rd_value;
   } cdb_prf_t;

   // Reservation station wakeup tag.
   typedef struct packed {
      logic                valid;
      logic [PRF_IDX-1:0]  rd_phy;
   } cdb_rs_t;

   // RAT ready-bit set.
   typedef struct packed {
      logic                valid;
      logic [ARCH_IDX-1:0] rd_arch;
      logic [PRF_IDX-1:0]  rd_phy;
   } cdb_rat_t;

   // One registered broadcast lane inside the arbiter.
   typedef struct packed {
      logic                valid;
      logic [ROB_IDX-1:0]  rob_id;
      logic [ARCH_IDX-1:0] rd_arch;
      logic [PRF_IDX-1:0]  rd_phy;
      logic [XLEN-1:0]     rd_value;
      logic [XLEN-1:0]     rs1_dbg;
      logic [XLEN-1:0]     rs2_dbg;
   } cdb_lane_t;

   // Build a valid lane from a buffered FU result.
   function automatic cdb_lane_t lane_from_pkt(input fu_cdb_reg_t pkt);
      cdb_lane_t lane;
      lane.valid    = 1'b1;
      lane.rob_id   = pkt.rob_id;
      lane.rd_arch  = pkt.rd_arch;
      lane.rd_phy   = pkt.rd_phy;
      lane.rd_value = pkt.rd_value;
      lane.rs1_dbg  = pkt.rs1_dbg;
      lane.rs2_dbg  = pkt.rs2_dbg;
      return lane;
   endfunction

   // x0 is never written: the lane still completes in the ROB but
   // must not touch the PRF, RS or RAT.
   function automatic logic lane_writes_reg(input cdb_lane_t lane);
      return lane.valid && (lane.rd_arch != '0);
   endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// Round-robin multi-grant picker.
// Scans the request vector starting at ptr (wrapping mod N_SRC) and hands the
// first N_LANE requesters to lanes 0..N_LANE-1 in scan order. next_ptr points
// one past the last granted source. Purely combinational.
module rr_multi_grant #(
   parameter int N_SRC  = 4,
   parameter int N_LANE = 2,
   parameter int PTR_W  = 2
) (
   input  logic [N_SRC-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_SRC-1:0] grant_lane [N_LANE],
   output logic [N_SRC-1:0] grant,
   output logic             any_grant,
   output logic [PTR_W-1:0] next_ptr
);

   // Walk the sources in rotated order and assign winners to lanes.
   // NOTE: every output gets a default before the loops so no path leaves
   // a signal unassigned, which would otherwise infer a latch.
   always_comb begin : scan
      int taken;
      taken    = 0;
      grant    = '0;
      next_ptr = ptr;
      for (int k = 0; k < N_LANE; k++) begin
         grant_lane[k] = '0;
      end
      for (int o = 0; o < N_SRC; o++) begin
         for (int s = 0; s < N_SRC; s++) begin
            // Source s sits at scan offset o when s == (ptr + o) mod N_SRC.
            if (((int'(ptr) + o) % N_SRC) == s && req[s] && taken < N_LANE) begin
               for (int k = 0; k < N_LANE; k++) begin
                  if (taken == k) begin
                     grant_lane[k][s] = 1'b1;
                  end
               end
               grant[s] = 1'b1;
               taken    = taken + 1;
               next_ptr = PTR_W'((s + 1) % N_SRC);
            end
         end
      end
      any_grant = |grant;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: receiving end of the FU writeback path.
// Each FU source owns a one-entry slot. Occupied slots are granted round-robin,
// up to N_LANE per cycle, into registered broadcast lanes that feed the PRF,
// reservation stations, RAT and ROB. A slot can be refilled in the same cycle
// it is granted, so a continuously granted source sustains one packet/cycle.
module cdb_arbiter
   import int_rs_types::*;
#(
   parameter int N_SRC  = CDB_SRC,
   parameter int N_LANE = CDB_WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic [N_SRC-1:0]    fu_valid,
   output logic [N_SRC-1:0]    fu_ready,
   input  fu_cdb_reg_t         fu_pkt    [N_SRC],
   output cdb_prf_t            cdb_prf   [N_LANE],
   output cdb_rs_t             cdb_rs    [N_LANE],
   output cdb_rat_t            cdb_rat   [N_LANE],
   output logic [N_LANE-1:0]   rob_valid,
   output logic [ROB_IDX-1:0]  rob_id    [N_LANE],
   output logic [XLEN-1:0]     dbg_rs1   [N_LANE],
   output logic [XLEN-1:0]     dbg_rs2   [N_LANE]
);

   localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   // Source slots.
   logic [N_SRC-1:0]  slot_v;
   fu_cdb_reg_t       slot_pkt [N_SRC];
   logic [N_SRC-1:0]  accept;

   // Arbitration.
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  next_ptr;
   logic [N_SRC-1:0]  grant;
   logic [N_SRC-1:0]  grant_lane [N_LANE];
   logic              any_grant;

   // Broadcast lanes.
   cdb_lane_t         lane_d [N_LANE];
   cdb_lane_t         lane_q [N_LANE];

   rr_multi_grant #(
      .N_SRC  (N_SRC),
      .N_LANE (N_LANE),
      .PTR_W  (PTR_W)
   ) u_grant (
      .req        (slot_v),
      .ptr        (rr_ptr),
      .grant_lane (grant_lane),
      .grant      (grant),
      .any_grant  (any_grant),
      .next_ptr   (next_ptr)
   );

   // Handshake: a slot takes a new packet when empty or draining this cycle;
   // nothing is accepted while a flush is in progress.
   always_comb begin
      fu_ready = flush ? '0 : (~slot_v | grant);
      accept   = fu_valid & fu_ready;
   end

   // Slot occupancy and round-robin pointer; flush empties slots, keeps rr_ptr.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_v <= '0;
         rr_ptr <= '0;
      end else if (flush) begin
         slot_v <= '0;
      end else begin
         slot_v <= accept | (slot_v & ~grant);
         if (any_grant) begin
            rr_ptr <= next_ptr;
         end
      end
   end

   // Slot payload capture on accept.
   // NOTE: payload flops carry no reset; slot_v qualifies them, so only the
   // control bits need a defined value out of reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_SRC; i++) begin
         if (accept[i]) begin
            slot_pkt[i] <= fu_pkt[i];
         end
      end
   end

   // Route each lane's one-hot winner onto that lane; empty lanes stay zero.
   always_comb begin
      for (int k = 0; k < N_LANE; k++) begin
         lane_d[k] = '0;
         for (int s = 0; s < N_SRC; s++) begin
            if (grant_lane[k][s]) begin
               lane_d[k] = lane_from_pkt(slot_pkt[s]);
            end
         end
      end
   end

   // Lane output registers; flush drops whatever would have been broadcast.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_LANE; k++) begin
            lane_q[k] <= '0;
         end
      end else if (flush) begin
         for (int k = 0; k < N_LANE; k++) begin
            lane_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_LANE; k++) begin
            lane_q[k] <= lane_d[k];
         end
      end
   end

   // Fan the registered lanes out to each consumer's view.
   always_comb begin
      for (int k = 0; k < N_LANE; k++) begin
         rob_valid[k]        = lane_q[k].valid;
         rob_id[k]           = lane_q[k].rob_id;
         dbg_rs1[k]          = lane_q[k].rs1_dbg;
         dbg_rs2[k]          = lane_q[k].rs2_dbg;

         cdb_prf[k].valid    = lane_writes_reg(lane_q[k]);
         cdb_prf[k].rd_phy   = lane_q[k].rd_phy;
         cdb_prf[k].rd_value = lane_q[k].rd_value;

         cdb_rs[k].valid     = lane_writes_reg(lane_q[k]);
         cdb_rs[k].rd_phy    = lane_q[k].rd_phy;

         cdb_rat[k].valid    = lane_writes_reg(lane_q[k]);
         cdb_rat[k].rd_arch  = lane_q[k].rd_arch;
         cdb_rat[k].rd_phy   = lane_q[k].rd_phy;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: one instance with a single lane (A) and one with
// two lanes (B). Stimulus pushes expected broadcasts into per-instance queues;
// negedge monitors pop and compare whenever a lane presents rob_valid.
module tb_cdb_arbiter;
   import int_rs_types::*;

   typedef struct {
      int          lane;
      int          due;
      fu_cdb_reg_t p;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   int cyc   = 0;
   int n_vec = 0;
   int n_err = 0;

   exp_t qa[$];
   exp_t qb[$];

   // Instance A: 4 sources, 1 lane.
   logic [3:0]         a_valid;
   logic [3:0]         a_ready;
   fu_cdb_reg_t        a_pkt    [4];
   cdb_prf_t           a_prf    [1];
   cdb_rs_t            a_rs     [1];
   cdb_rat_t           a_rat    [1];
   logic [0:0]         a_rob_valid;
   logic [ROB_IDX-1:0] a_rob_id [1];
   logic [XLEN-1:0]    a_dbg1   [1];
   logic [XLEN-1:0]    a_dbg2   [1];

   // Instance B: 4 sources, 2 lanes.
   logic [3:0]         b_valid;
   logic [3:0]         b_ready;
   fu_cdb_reg_t        b_pkt    [4];
   cdb_prf_t           b_prf    [2];
   cdb_rs_t            b_rs     [2];
   cdb_rat_t           b_rat    [2];
   logic [1:0]         b_rob_valid;
   logic [ROB_IDX-1:0] b_rob_id [2];
   logic [XLEN-1:0]    b_dbg1   [2];
   logic [XLEN-1:0]    b_dbg2   [2];

   cdb_arbiter #(.N_SRC(4), .N_LANE(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .fu_valid(a_valid), .fu_ready(a_ready), .fu_pkt(a_pkt),
      .cdb_prf(a_prf), .cdb_rs(a_rs), .cdb_rat(a_rat),
      .rob_valid(a_rob_valid), .rob_id(a_rob_id),
      .dbg_rs1(a_dbg1), .dbg_rs2(a_dbg2)
   );

   cdb_arbiter #(.N_SRC(4), .N_LANE(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .fu_valid(b_valid), .fu_ready(b_ready), .fu_pkt(b_pkt),
      .cdb_prf(b_prf), .cdb_rs(b_rs), .cdb_rat(b_rat),
      .rob_valid(b_rob_valid), .rob_id(b_rob_id),
      .dbg_rs1(b_dbg1), .dbg_rs2(b_dbg2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic fu_cdb_reg_t mk(input int rob, input int arch, input int phy,
                                      input logic [31:0] val);
      fu_cdb_reg_t p;
      p.rob_id   = ROB_IDX'(rob);
      p.rd_arch  = ARCH_IDX'(arch);
      p.rd_phy   = PRF_IDX'(phy);
      p.rd_value = val;
      p.rs1_dbg  = val ^ 32'h0000_FFFF;
      p.rs2_dbg  = ~val;
      return p;
   endfunction

   // Contention-test packet: source s, sequence number q.
   function automatic fu_cdb_reg_t mk3(input int s, input int q);
      return mk(s * 8 + q, s + 1, 32 + s * 4 + q, 32'hC000_0000 + 32'(s * 256 + q));
   endfunction

   function automatic logic [63:0] beat_key(input int lane, input int at,
                                            input logic [ROB_IDX-1:0] rob,
                                            input logic [PRF_IDX-1:0] phy,
                                            input logic [2:0] vld,
                                            input logic [31:0] val);
      return {2'(lane), 16'(at), rob, phy, vld, val};
   endfunction

   task automatic push_a(input int due, input fu_cdb_reg_t p);
      exp_t e;
      e.lane = 0; e.due = due; e.p = p;
      qa.push_back(e);
   endtask

   task automatic push_b(input int lane, input int due, input fu_cdb_reg_t p);
      exp_t e;
      e.lane = lane; e.due = due; e.p = p;
      qb.push_back(e);
   endtask

   // Compare one presented lane against the popped expectation. When the
   // expected rd_arch is x0 the PRF payload is don't-care and masked on both sides.
   task automatic compare_beat(input string name, input int lane,
                               input logic [ROB_IDX-1:0] rob, input cdb_prf_t prf,
                               input logic rsv, input logic ratv,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input exp_t e);
      logic wr;
      wr = (e.p.rd_arch != '0);
      check({name, " hdr"},
            beat_key(lane, cyc, rob, wr ? prf.rd_phy : '0, {prf.valid, rsv, ratv},
                     wr ? prf.rd_value : '0),
            beat_key(e.lane, e.due, e.p.rob_id, wr ? e.p.rd_phy : '0, {3{wr}},
                     wr ? e.p.rd_value : '0));
      check({name, " dbg"}, {d1, d2}, {e.p.rs1_dbg, e.p.rs2_dbg});
   endtask

   // Monitor for instance A.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (a_rob_valid[0]) begin
            if (qa.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL A unexpected beat: got rob_id %0d at cycle %0d, expected none",
                        a_rob_id[0], cyc);
            end else begin
               e = qa.pop_front();
               compare_beat("A beat", 0, a_rob_id[0], a_prf[0], a_rs[0].valid,
                            a_rat[0].valid, a_dbg1[0], a_dbg2[0], e);
            end
         end else begin
            check("A idle strobes", {a_prf[0].valid, a_rs[0].valid, a_rat[0].valid}, '0);
         end
      end
   end

   // Monitor for instance B; lane 0 is popped before lane 1 each cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            if (b_rob_valid[k]) begin
               if (qb.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL B unexpected beat: got lane %0d rob_id %0d at cycle %0d, expected none",
                           k, b_rob_id[k], cyc);
               end else begin
                  e = qb.pop_front();
                  compare_beat("B beat", k, b_rob_id[k], b_prf[k], b_rs[k].valid,
                               b_rat[k].valid, b_dbg1[k], b_dbg2[k], e);
               end
            end else begin
               check("B idle strobes", {b_prf[k].valid, b_rs[k].valid, b_rat[k].valid}, '0);
            end
         end
      end
   end

   initial begin
      int          seq [4];
      logic [3:0]  acc;
      int          c0;

      a_valid = '0;
      b_valid = '0;
      for (int s = 0; s < 4; s++) begin
         a_pkt[s] = '0;
         b_pkt[s] = '0;
      end

      // T1: reset held mid-cycle, then released.
      #3;
      check("T1 A rob_valid in reset", a_rob_valid, '0);
      check("T1 B rob_valid in reset", b_rob_valid, '0);
      check("T1 A prf in reset", a_prf[0], '0);
      check("T1 B rob_id in reset", {b_rob_id[0], b_rob_id[1]}, '0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("T1 A ready after reset", a_ready, 4'hF);
      check("T1 B ready after reset", b_ready, 4'hF);
      tick();

      // T2: single source, back-to-back, in order, one per cycle.
      for (int n = 0; n < 8; n++) begin
         a_valid  = 4'b0100;
         a_pkt[2] = mk(5, 3, 17, 32'hDEAD + 32'(n));
         push_a(cyc + 2, a_pkt[2]);
         @(negedge clk);
         check("T2 ready src2", a_ready[2], 1'b1);
         tick();
      end
      a_valid = '0;
      repeat (4) tick();

      // T1b: reset asserted while a beat is on the lane discards it at once.
      a_valid  = 4'b0001;
      a_pkt[0] = mk(7, 7, 7, 32'h7777_7777);
      tick();
      a_valid = '0;
      tick();
      check("T1b beat before reset", a_rob_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("T1b rob_valid in reset", a_rob_valid, '0);
      check("T1b prf valid in reset", a_prf[0].valid, '0);
      check("T1b rob_id in reset", a_rob_id[0], '0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("T1b ready after reset", a_ready, 4'hF);
      tick();

      // T3: all four sources valid every cycle, one lane -> 0,1,2,3,0,...
      for (int s = 0; s < 4; s++) seq[s] = 0;
      c0 = cyc;
      for (int m = 0; m < 12; m++) push_a(c0 + 2 + m, mk3(m % 4, m / 4));
      for (int t = 0; t < 9; t++) begin
         a_valid = 4'hF;
         for (int s = 0; s < 4; s++) a_pkt[s] = mk3(s, seq[s]);
         @(negedge clk);
         check("T3 ready", a_ready, (t == 0) ? 4'hF : (4'b0001 << ((t - 1) % 4)));
         acc = a_valid & a_ready;
         tick();
         for (int s = 0; s < 4; s++) if (acc[s]) seq[s]++;
      end
      a_valid = '0;
      repeat (6) tick();

      // T5: rd_arch = x0 completes in the ROB only.
      a_valid  = 4'b0010;
      a_pkt[1] = mk(9, 0, 40, 32'h5555_AAAA);
      push_a(cyc + 2, a_pkt[1]);
      tick();
      a_valid = '0;
      repeat (3) tick();

      // T4: two lanes; rr_ptr steered to 1 with slots 0,1,3 occupied.
      c0       = cyc;
      b_valid  = 4'b0001;
      b_pkt[0] = mk(1, 1, 10, 32'h100);
      push_b(0, c0 + 2, b_pkt[0]);
      tick();
      b_valid  = 4'b1011;
      b_pkt[0] = mk(2, 2, 11, 32'h200);
      b_pkt[1] = mk(3, 3, 12, 32'h300);
      b_pkt[3] = mk(4, 4, 13, 32'h400);
      push_b(0, c0 + 3, b_pkt[1]);
      push_b(1, c0 + 3, b_pkt[3]);
      push_b(0, c0 + 4, b_pkt[0]);
      @(negedge clk);
      check("T4 ready", b_ready, 4'hF);
      tick();
      b_valid = '0;
      repeat (4) tick();

      // T6: flush with three slots full and both lanes valid.
      c0 = cyc;
      b_valid = 4'hF;
      for (int s = 0; s < 4; s++) b_pkt[s] = mk(16 + s, s + 1, 20 + s, 32'hF00 + 32'(s));
      push_b(0, c0 + 2, b_pkt[1]);
      push_b(1, c0 + 2, b_pkt[2]);
      tick();
      b_valid  = 4'b0010;
      b_pkt[1] = mk(21, 2, 25, 32'hF10);
      tick();
      flush   = 1'b1;
      b_valid = 4'hF;
      @(negedge clk);
      check("T6 B ready during flush", b_ready, '0);
      check("T6 A ready during flush", a_ready, '0);
      tick();
      flush   = 1'b0;
      b_valid = '0;
      repeat (4) tick();
      // rr_ptr kept at 3 across the flush: scan order 3,0 then 1.
      c0       = cyc;
      b_valid  = 4'b1011;
      b_pkt[0] = mk(24, 1, 30, 32'hA0);
      b_pkt[1] = mk(25, 2, 31, 32'hA1);
      b_pkt[3] = mk(26, 4, 33, 32'hA3);
      push_b(0, c0 + 2, b_pkt[3]);
      push_b(1, c0 + 2, b_pkt[0]);
      push_b(0, c0 + 3, b_pkt[1]);
      @(negedge clk);
      check("T6 B ready after flush", b_ready, 4'hF);
      tick();
      b_valid = '0;
      repeat (4) tick();

      check("A scoreboard drained", qa.size(), 0);
      check("B scoreboard drained", qb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
